// File: rtl/radix_div.sv
// radix_div: sequential signed 8/4 restoring divider, truncating toward zero.
// Works on magnitudes for 8 steps, then applies signs in a final fix-up cycle.
module radix_div (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_zero,
    output logic       ovf
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t r_state, w_next;
    logic [7:0] r_dvd;
    logic [3:0] r_dsr;
    logic [3:0] r_prem;
    logic [3:0] r_cnt;
    logic       r_neg_q;
    logic       r_neg_r;
    logic [4:0] w_shift;
    logic       w_fit;
    logic       w_go;
    logic       w_zero;
    // r_dvd doubles as the quotient shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    assign w_shift = {r_prem, r_dvd[7]};
    assign w_fit   = w_shift >= {1'b0, r_dsr};
    assign w_zero  = divisor == 4'd0;
    assign w_go    = start && !w_zero;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? CALC : IDLE;
            CALC:    w_next = (r_cnt == 4'd7) ? FIX : CALC;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_prem    <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            r_state <= w_next;
            done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && w_zero) begin
                        quotient  <= '0;
                        remainder <= '0;
                        div_zero  <= 1'b1;
                        ovf       <= 1'b0;
                        done      <= 1'b1;
                    end else if (w_go) begin
                        r_dvd   <= dividend[7] ? -dividend : dividend;
                        r_dsr   <= divisor[3] ? -divisor : divisor;
                        r_neg_q <= dividend[7] ^ divisor[3];
                        r_neg_r <= dividend[7];
                        r_prem  <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    // Both branches fit in 4 bits because the partial remainder stays below |divisor| <= 8.
                    r_prem <= w_fit ? w_shift[3:0] - r_dsr : w_shift[3:0];
                    r_dvd  <= {r_dvd[6:0], w_fit};
                    r_cnt  <= r_cnt + 4'd1;
                end
                FIX: begin
                    quotient  <= r_neg_q ? -r_dvd : r_dvd;
                    remainder <= r_neg_r ? -r_prem : r_prem;
                    ovf       <= (r_dvd == 8'h80) && !r_neg_q;
                    div_zero  <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
